// File: rtl/minc_prog_loader.sv
// Program memory and loader for the minc core: length-prefixed byte load, then registered fetch.
// Optional checksum byte after the data is enabled by defining MINC_LOADER_CHECKSUM_EN.
module minc_prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ld_start,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [8:0]        load_count
);

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] ptr;
   logic [8:0]        len;
   logic              in_load;
   logic              xfer;
   logic [8:0]        count_next;
   logic              last_data;

   // A restart pulse wins over a byte offered in the same cycle, so that byte is refused.
   assign in_load    = (state == LEN) || (state == DATA) || (state == CSUM);
   assign ld_ready   = in_load && !ld_start;
   assign xfer       = ld_valid && ld_ready;
   assign count_next = load_count + 9'd1;
   assign last_data  = (count_next == len);

`ifdef MINC_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_next;
   assign sum_next = sum + ld_data;
`else
   assign load_err = 1'b0;
`endif

   // Program memory has no reset so an image survives a reset of the loader.
   always_ff @(posedge CLK) begin
      if (!RESET && state == DATA && xfer) begin
         mem[ptr] <= ld_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         ptr         <= '0;
         len         <= 9'd0;
         load_count  <= 9'd0;
         cpu_hold    <= 1'b1;
         load_done   <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
`ifdef MINC_LOADER_CHECKSUM_EN
         sum         <= 8'd0;
         load_err    <= 1'b0;
`endif
      end else begin
         fetch_valid <= 1'b0;
         if (ld_start) begin
            state      <= LEN;
            load_count <= 9'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
`ifdef MINC_LOADER_CHECKSUM_EN
            sum        <= 8'd0;
            load_err   <= 1'b0;
`endif
         end else begin
            case (state)
               LEN: begin
                  if (xfer) begin
                     len        <= (ld_data == '0) ? 9'd256 : {1'b0, ld_data};
                     load_count <= 9'd0;
                     ptr        <= '0;
`ifdef MINC_LOADER_CHECKSUM_EN
                     sum        <= 8'd0;
`endif
                     state      <= DATA;
                  end
               end
               DATA: begin
                  if (xfer) begin
                     ptr        <= ptr + 1'b1;
                     load_count <= count_next;
`ifdef MINC_LOADER_CHECKSUM_EN
                     sum        <= sum_next;
                     if (last_data) begin
                        state <= CSUM;
                     end
`else
                     if (last_data) begin
                        state     <= RUN;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                     end
`endif
                  end
               end
`ifdef MINC_LOADER_CHECKSUM_EN
               CSUM: begin
                  if (xfer) begin
                     if (sum_next == 8'd0) begin
                        state     <= RUN;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                     end else begin
                        state    <= ERR;
                        load_err <= 1'b1;
                     end
                  end
               end
`endif
               RUN: begin
                  if (fetch_req) begin
                     fetch_data  <= mem[fetch_addr];
                     fetch_valid <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
